format_scan_multilane: RTL and testbench

- Next-generation format scanner: classifies `lanes` instructions per cycle by primary opcode into a one-hot-OR format mask.
- Sits between fetch and the format-specific decoders.
- Replaces enable/stall with a valid/ready handshake and a 2-entry skid buffer.
- Invalid opcodes are flagged rather than dropped, and counted.

---
 rtl/format_scan_multilane.sv | 208 ++++++++++++++++++++
 tb/tb_format_scan_multilane.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/format_scan_multilane.sv
// Multi-lane primary-opcode format scanner with valid/ready handshake,
// a 2-entry output/skid buffer and a saturating invalid-lane counter.
module format_scan_multilane #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 6,
    parameter int formatWidth             = 26,
    parameter int lanes                   = 2,
    parameter int countWidth              = 16
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 flush_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [lanes-1:0]                     laneValid_i,
    input  logic [lanes*instructionWidth-1:0]    instruction_i,
    input  logic [addressWidth-1:0]              instructionAddress_i,
    input  logic [PidSize-1:0]                   instructionPid_i,
    input  logic [TidSize-1:0]                   instructionTid_i,
    input  logic [instructionCounterWidth-1:0]   instructionMajId_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [lanes-1:0]                     laneValid_o,
    output logic [lanes-1:0]                     invalid_o,
    output logic [lanes*formatWidth-1:0]         instFormat_o,
    output logic [lanes*opcodeSize-1:0]          instOpcode_o,
    output logic [lanes*instructionWidth-1:0]    instruction_o,
    output logic [lanes*addressWidth-1:0]        instructionAddress_o,
    output logic [lanes*instructionCounterWidth-1:0] instructionMajId_o,
    output logic [PidSize-1:0]                   instructionPid_o,
    output logic [TidSize-1:0]                   instructionTid_o,
    output logic [countWidth-1:0]                invalidCount_o
);

    localparam int F_A = 0, F_B = 1, F_D = 2, F_DQ = 3, F_DS = 4, F_DX = 5;
    localparam int F_I = 6, F_M = 7, F_MD = 8, F_MDS = 9, F_SC = 10;
    localparam int F_VA = 11, F_VC = 12, F_VX = 13, F_X = 14, F_XFL = 15;
    localparam int F_XFX = 16, F_XL = 17, F_XO = 18, F_XS = 19;
    localparam int F_XX2 = 20, F_XX3 = 21, F_Z22 = 23, F_Z23 = 24;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [lanes-1:0]                         lane_valid;
        logic [lanes-1:0]                         invalid;
        logic [lanes*formatWidth-1:0]             format;
        logic [lanes*opcodeSize-1:0]              opcode;
        logic [lanes*instructionWidth-1:0]        instruction;
        logic [lanes*addressWidth-1:0]            address;
        logic [lanes*instructionCounterWidth-1:0] maj_id;
        logic [PidSize-1:0]                       pid;
        logic [TidSize-1:0]                       tid;
    } bundle_t;

    // Headroom for up to 8 lanes of increment on top of a full counter
    typedef logic [countWidth+3:0] sum_t;

    function automatic logic [formatWidth-1:0] decode(input logic [opcodeSize-1:0] op);
        logic [formatWidth-1:0] f;
        f = '0;
        case (int'(op)) inside
            18: f[F_I] = 1'b1;
            16: f[F_B] = 1'b1;
            17: f[F_SC] = 1'b1;
            19: begin f[F_XL] = 1'b1; f[F_DX] = 1'b1; end
            2, 3, 7, 8, [10:15], [24:29], [32:55]: f[F_D] = 1'b1;
            57, 58, 61, 62: f[F_DS] = 1'b1;
            56: f[F_DQ] = 1'b1;
            20, 21, 23: f[F_M] = 1'b1;
            30: begin f[F_MD] = 1'b1; f[F_MDS] = 1'b1; end
            31: begin
                f[F_X] = 1'b1; f[F_XO] = 1'b1; f[F_Z23] = 1'b1;
                f[F_A] = 1'b1; f[F_XS] = 1'b1; f[F_XFX] = 1'b1;
            end
            4: begin f[F_VA] = 1'b1; f[F_VX] = 1'b1; f[F_VC] = 1'b1; end
            59: begin
                f[F_A] = 1'b1; f[F_X] = 1'b1;
                f[F_Z22] = 1'b1; f[F_Z23] = 1'b1;
            end
            60: begin f[F_XX2] = 1'b1; f[F_XX3] = 1'b1; end
            63: begin
                f[F_A] = 1'b1; f[F_X] = 1'b1; f[F_XFL] = 1'b1;
                f[F_Z22] = 1'b1; f[F_Z23] = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    state_t state, state_n;
    bundle_t in_b, out_q, skid_q;
    logic ready_q;
    logic [countWidth-1:0] count_q;
    sum_t pop, sum;
    logic accept, load;
    logic out_we, out_from_skid, skid_we;

    // Lane 0 occupies the most significant slot of every packed lane vector
    always_comb begin
        logic [instructionWidth-1:0] ins;
        logic [opcodeSize-1:0] op;
        logic [formatWidth-1:0] fmt;
        int slot;
        in_b = '0;
        pop = '0;
        ins = '0;
        op = '0;
        fmt = '0;
        slot = 0;
        in_b.lane_valid = laneValid_i;
        in_b.instruction = instruction_i;
        in_b.pid = instructionPid_i;
        in_b.tid = instructionTid_i;
        for (int k = 0; k < lanes; k++) begin
            slot = lanes - 1 - k;
            ins = instruction_i[slot*instructionWidth +: instructionWidth];
            op = ins[instructionWidth-1 -: opcodeSize];
            fmt = decode(op);
            in_b.opcode[slot*opcodeSize +: opcodeSize] = op;
            in_b.format[slot*formatWidth +: formatWidth] = fmt;
            in_b.invalid[slot] = laneValid_i[slot] && (fmt == '0);
            in_b.address[slot*addressWidth +: addressWidth] =
                instructionAddress_i + addressWidth'(4 * k);
            in_b.maj_id[slot*instructionCounterWidth +: instructionCounterWidth] =
                instructionMajId_i + instructionCounterWidth'(k);
            pop = pop + sum_t'(in_b.invalid[slot]);
        end
    end

    assign accept = valid_i && ready_q && !flush_i;
    assign load = accept && (laneValid_i != '0);
    assign sum = sum_t'(count_q) + pop;

    always_comb begin
        state_n = state;
        out_we = 1'b0;
        out_from_skid = 1'b0;
        skid_we = 1'b0;
        case (state)
            EMPTY: begin
                if (load) begin
                    state_n = ONE;
                    out_we = 1'b1;
                end
            end
            ONE: begin
                if (load && ready_i) begin
                    out_we = 1'b1;
                end else if (load) begin
                    state_n = TWO;
                    skid_we = 1'b1;
                end else if (ready_i) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (ready_i) begin
                    state_n = ONE;
                    out_we = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
        if (flush_i) begin
            state_n = EMPTY;
            out_we = 1'b0;
            skid_we = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state <= EMPTY;
            ready_q <= 1'b1;
            out_q <= '0;
            skid_q <= '0;
            count_q <= '0;
        end else begin
            state <= state_n;
            ready_q <= (state_n != TWO);
            if (out_we) out_q <= out_from_skid ? skid_q : in_b;
            if (skid_we) skid_q <= in_b;
            if (accept) begin
                if (sum > sum_t'({countWidth{1'b1}})) count_q <= '1;
                else count_q <= sum[countWidth-1:0];
            end
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (state != EMPTY);
    assign laneValid_o = out_q.lane_valid;
    assign invalid_o = out_q.invalid;
    assign instFormat_o = out_q.format;
    assign instOpcode_o = out_q.opcode;
    assign instruction_o = out_q.instruction;
    assign instructionAddress_o = out_q.address;
    assign instructionMajId_o = out_q.maj_id;
    assign instructionPid_o = out_q.pid;
    assign instructionTid_o = out_q.tid;
    assign invalidCount_o = count_q;

endmodule

// File: tb/tb_format_scan_multilane.sv
// Bench for format_scan_multilane: directed scenarios then random traffic,
// all checked against a queue-based reference of the scanner.
module tb_format_scan_multilane;

    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i, flush_i, valid_i, ready_o, valid_o, ready_i;
    logic [1:0] laneValid_i, laneValid_o, invalid_o;
    logic [63:0] instruction_i, instruction_o;
    logic [63:0] instructionAddress_i, instructionMajId_i;
    logic [19:0] instructionPid_i, instructionPid_o;
    logic [15:0] instructionTid_i, instructionTid_o;
    logic [51:0] instFormat_o;
    logic [11:0] instOpcode_o;
    logic [127:0] instructionAddress_o, instructionMajId_o;
    logic [CW-1:0] invalidCount_o;

    format_scan_multilane #(.countWidth(CW)) dut (
        .clock_i(clk),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .laneValid_i(laneValid_i),
        .instruction_i(instruction_i),
        .instructionAddress_i(instructionAddress_i),
        .instructionPid_i(instructionPid_i),
        .instructionTid_i(instructionTid_i),
        .instructionMajId_i(instructionMajId_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .laneValid_o(laneValid_o),
        .invalid_o(invalid_o),
        .instFormat_o(instFormat_o),
        .instOpcode_o(instOpcode_o),
        .instruction_o(instruction_o),
        .instructionAddress_o(instructionAddress_o),
        .instructionMajId_o(instructionMajId_o),
        .instructionPid_o(instructionPid_o),
        .instructionTid_o(instructionTid_o),
        .invalidCount_o(invalidCount_o)
    );

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] ins;
        logic [63:0] addr;
        logic [63:0] maj;
        logic [19:0] pid;
        logic [15:0] tid;
    } bun_t;

    int tests = 0;
    int fails = 0;
    int cnt_m = 0;
    bun_t q[$];
    logic [25:0] fmt_tab[64];

    function automatic logic [25:0] fb(input int n);
        return 26'd1 << n;
    endfunction

    task automatic build_table();
        foreach (fmt_tab[i]) fmt_tab[i] = '0;
        fmt_tab[18] = fb(6);
        fmt_tab[16] = fb(1);
        fmt_tab[17] = fb(10);
        fmt_tab[19] = fb(17) | fb(5);
        foreach (fmt_tab[i])
            if (i == 2 || i == 3 || i == 7 || i == 8 || (i >= 10 && i <= 15) ||
                (i >= 24 && i <= 29) || (i >= 32 && i <= 55))
                fmt_tab[i] = fb(2);
        fmt_tab[57] = fb(4);
        fmt_tab[58] = fb(4);
        fmt_tab[61] = fb(4);
        fmt_tab[62] = fb(4);
        fmt_tab[56] = fb(3);
        fmt_tab[20] = fb(7);
        fmt_tab[21] = fb(7);
        fmt_tab[23] = fb(7);
        fmt_tab[30] = fb(8) | fb(9);
        fmt_tab[31] = fb(14) | fb(18) | fb(24) | fb(0) | fb(19) | fb(16);
        fmt_tab[4] = fb(11) | fb(13) | fb(12);
        fmt_tab[59] = fb(0) | fb(14) | fb(23) | fb(24);
        fmt_tab[60] = fb(20) | fb(21);
        fmt_tab[63] = fb(0) | fb(14) | fb(15) | fb(23) | fb(24);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        bun_t b;
        logic [31:0] w;
        logic [5:0] op;
        logic [51:0] ef;
        logic [11:0] eo;
        logic [1:0] ei;
        logic [127:0] ea, em;
        chk("valid_o", valid_o, q.size() > 0);
        chk("ready_o", ready_o, q.size() < 2);
        chk("count", invalidCount_o, cnt_m);
        if (q.size() > 0) begin
            b = q[0];
            for (int k = 0; k < 2; k++) begin
                w = b.ins[(1-k)*32 +: 32];
                op = w[31:26];
                ef[(1-k)*26 +: 26] = fmt_tab[op];
                eo[(1-k)*6 +: 6] = op;
                ei[1-k] = b.lv[1-k] && (fmt_tab[op] == '0);
                ea[(1-k)*64 +: 64] = b.addr + 64'(4 * k);
                em[(1-k)*64 +: 64] = b.maj + 64'(k);
            end
            chk("lanevalid", laneValid_o, b.lv);
            chk("invalid", invalid_o, ei);
            chk("format", instFormat_o, ef);
            chk("opcode", instOpcode_o, eo);
            chk("instr", instruction_o, b.ins);
            chk("addr", instructionAddress_o, ea);
            chk("majid", instructionMajId_o, em);
            chk("pid", instructionPid_o, b.pid);
            chk("tid", instructionTid_o, b.tid);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_lv"}, laneValid_o, 0);
        chk({tag, "_inv"}, invalid_o, 0);
        chk({tag, "_fmt"}, instFormat_o, 0);
        chk({tag, "_op"}, instOpcode_o, 0);
        chk({tag, "_ins"}, instruction_o, 0);
        chk({tag, "_addr"}, instructionAddress_o, 0);
        chk({tag, "_maj"}, instructionMajId_o, 0);
        chk({tag, "_pid"}, instructionPid_o, 0);
        chk({tag, "_tid"}, instructionTid_o, 0);
    endtask

    task automatic drive(input bit v, input logic [1:0] lv, input logic [5:0] o0,
                         input logic [5:0] o1, input logic [63:0] a,
                         input logic [63:0] m, input bit rdy, input bit fl);
        valid_i = v;
        laneValid_i = lv;
        instruction_i = {o0, 26'($urandom), o1, 26'($urandom)};
        instructionAddress_i = a;
        instructionMajId_i = m;
        instructionPid_i = 20'($urandom);
        instructionTid_i = 16'($urandom);
        ready_i = rdy;
        flush_i = fl;
    endtask

    task automatic tick();
        int p;
        logic [5:0] op;
        bun_t b;
        if (!reset_i) begin
            q.delete();
            cnt_m = 0;
        end else if (flush_i) begin
            q.delete();
        end else begin
            bit acc;
            acc = valid_i && (q.size() < 2);
            if (q.size() > 0 && ready_i) q.delete(0);
            if (acc) begin
                p = 0;
                for (int k = 0; k < 2; k++) begin
                    op = instruction_i[(1-k)*32 + 26 +: 6];
                    if (laneValid_i[1-k] && fmt_tab[op] == '0) p++;
                end
                if (laneValid_i != 2'b00) begin
                    b.lv = laneValid_i;
                    b.ins = instruction_i;
                    b.addr = instructionAddress_i;
                    b.maj = instructionMajId_i;
                    b.pid = instructionPid_i;
                    b.tid = instructionTid_i;
                    q.push_back(b);
                end
                cnt_m = (cnt_m + p > 15) ? 15 : cnt_m + p;
            end
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic logic [5:0] rand_op();
        return 6'($urandom);
    endfunction

    initial begin
        build_table();
        reset_i = 1'b0;
        drive(1, 2'b11, 18, 31, 64'h1000, 64'd7, 1, 0);
        tick();
        tick();
        check_zero("reset");
        reset_i = 1'b1;

        drive(1, 2'b11, 18, 31, 64'h1000, 64'd100, 1, 0);
        tick();
        drive(1, 2'b11, 30, 63, 64'h1000, 64'd200, 1, 0);
        tick();
        drive(1, 2'b11, 59, 0, 64'h1000, 64'd300, 1, 0);
        tick();
        chk("sweep_inv", invalid_o, 2'b01);
        chk("sweep_addr", instructionAddress_o, {64'h1000, 64'h1004});
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
        tick();
        chk("sweep_cnt", invalidCount_o, 1);

        drive(1, 2'b11, 16, 17, 64'h2000, 64'd1, 0, 0);
        tick();
        drive(1, 2'b10, 19, 4, 64'h3000, 64'd2, 0, 0);
        tick();
        chk("bp_ready", ready_o, 0);
        drive(1, 2'b01, 56, 57, 64'h4000, 64'd3, 0, 0);
        tick();
        tick();
        chk("bp_held", instructionAddress_o[127:64], 64'h2000);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        drive(1, 2'b11, 20, 21, 64'h5000, 64'd4, 0, 0);
        tick();
        drive(1, 2'b11, 23, 60, 64'h6000, 64'd5, 0, 0);
        tick();
        drive(1, 2'b11, 2, 3, 64'h7000, 64'd6, 1, 1);
        tick();
        chk("flush_valid", valid_o, 0);
        chk("flush_ready", ready_o, 1);
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
        tick();

        drive(1, 2'b11, 18, 18, 64'hFFFF_FFFF_FFFF_FFFC, '1, 1, 0);
        tick();
        chk("wrap_addr", instructionAddress_o[63:0], 0);
        chk("wrap_maj", instructionMajId_o[63:0], 0);
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(1, 2'b11, 0, 1, 64'(i), 64'(i), 1, 0);
            tick();
        end
        chk("sat_cnt", invalidCount_o, 15);
        drive(0, 2'b00, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 2'b00, 18, 18, 64'h8000, 0, 1, 0);
        tick();
        chk("empty_valid", valid_o, 0);

        drive(1, 2'b11, 24, 25, 64'h9000, 64'd8, 0, 0);
        tick();
        drive(1, 2'b11, 26, 27, 64'hA000, 64'd9, 0, 0);
        tick();
        reset_i = 1'b0;
        drive(1, 2'b11, 28, 29, 64'hB000, 64'd10, 0, 0);
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_cnt", invalidCount_o, 0);
        check_zero("midrst");
        reset_i = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            reset_i = ($urandom % 300) != 0;
            drive(($urandom % 4) != 0, 2'($urandom), rand_op(), rand_op(),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom % 3) != 0, ($urandom % 32) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
